// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier with its stall/done controller.
// Serves mul, mulh, mulhsu and mulhu with a fixed XLEN+2 cycle latency.
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mulsel,
  input  logic            kill,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg;
  logic [2:0]        sel;
  logic [2*XLEN:0]   acc;

  logic              valid_sel;
  logic              a_signed;
  logic              b_signed;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;
  logic              accept;
  logic              last;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN:0]   acc_nxt;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   res_fix;

  always_comb begin
    valid_sel = 1'b0;
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    unique case (mulsel)
      3'b001: valid_sel = 1'b1;
      3'b010: begin
        valid_sel = 1'b1;
        a_signed  = 1'b1;
        b_signed  = 1'b1;
      end
      3'b011: begin
        valid_sel = 1'b1;
        a_signed  = 1'b1;
      end
      3'b100: valid_sel = 1'b1;
      default: ;
    endcase
  end

  assign sign_a   = a_signed & op_a[XLEN-1];
  assign sign_b   = b_signed & op_b[XLEN-1];
  assign mag_a_in = sign_a ? -op_a : op_a;
  assign mag_b_in = sign_b ? -op_b : op_b;

  assign accept = (state == IDLE) & start & ~kill & valid_sel;
  assign last   = (count == CNT_W'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (kill)      state_nxt = IDLE;
        else if (last) state_nxt = FIX;
      end
      FIX: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Upper half absorbs the partial product, then the whole accumulator shifts.
  assign addend  = mag_b[0] ? mag_a : '0;
  assign sum     = acc[2*XLEN:XLEN] + {1'b0, addend};
  assign acc_nxt = {1'b0, sum, acc[XLEN-1:1]};

  assign p       = neg ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
  assign res_fix = (sel == 3'b001) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      sel    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mag_a <= mag_a_in;
        mag_b <= mag_b_in;
        neg   <= sign_a ^ sign_b;
        sel   <= mulsel;
        acc   <= '0;
        count <= '0;
      end else if (state == BUSY && !kill) begin
        acc   <= acc_nxt;
        mag_b <= mag_b >> 1;
        count <= count + 1'b1;
      end else if (state == FIX && !kill) begin
        result <= res_fix;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Iterative multi-cycle multiply unit plus its controller for the Mini-RISC-V execute stage.
- Accepts the decoder's mul_inst/mulsel encoding (001 mul, 010 mulh, 011 mulhsu, 100 mulhu) with two register operands.
- Runs a radix-2 shift-add over magnitudes, applies sign correction, and returns the low or high result word.
- Holds the pipeline through a stall output while busy. Fixed latency, independent of operand values.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; mul_inst qualified by the decoder (not flushed).
- mulsel  in  3  operation select; 001 mul, 010 mulh, 011 mulhsu, 100 mulhu.
- kill  in  1  pipeline flush; aborts any operation in progress.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- stall  out  1  holds pipeline; combinational.
- done  out  1  one-cycle pulse; result valid in the same cycle.
- result  out  XLEN  registered result; holds its value until the next done.

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. On rst: state=IDLE, count=0, done=0, result=0, internal product register=0. rst mid-operation abandons it; no done pulse.
- States: IDLE, BUSY, FIX.
- IDLE:
  - Accept when start=1, kill=0 and mulsel is in {001..100}. Ignore mulsel 000 or 101..111: no stall, stay in IDLE.
  - On accept, latch:
    - mag_a = |op_a| if a is signed (mulh, mulhsu), else op_a.
    - mag_b = |op_b| if b is signed (mulh only), else op_b.
    - neg = sign_a XOR sign_b, counting signed operands only.
    - sel = mulsel.
    - product = 0, count = 0.
  - Go to BUSY.
- BUSY:
  - Each cycle: if mag_b[0], add mag_a into the upper half of the 2*XLEN+1-bit accumulator; shift right by 1; shift mag_b right by 1; count++.
  - After XLEN cycles (count==XLEN-1 at the edge), go to FIX.
- FIX:
  - p = neg ? -product : product (2*XLEN bits, two's complement).
  - result = p[XLEN-1:0] for mul, p[2*XLEN-1:XLEN] for the others.
  - done=1 in the next cycle. Go to IDLE.
- Timing: start high in cycle 0 -> BUSY in cycles 1..XLEN -> FIX in cycle XLEN+1 -> done in cycle XLEN+2 (34 for XLEN=32).
- stall = (state==IDLE && accept) || state!=IDLE. High in cycles 0..XLEN+1; low in the done cycle, so the pipeline advances and captures result.
- kill:
  - In BUSY or FIX: return to IDLE at the next edge; no done; result unchanged.
  - Concurrent with start in IDLE: start is ignored.
- start while BUSY/FIX is ignored; the decoder holds because stall is high.
- Magnitude of -2^(XLEN-1) is 2^(XLEN-1); this fits unsigned XLEN, so no overflow special case.
- A zero operand still takes the full latency.
- done is a single-cycle pulse. A back-to-back start in the done cycle is accepted: a new operation begins.

Test Plan:
- mul, a=7, b=6 -> stall high cycles 0..33; done in cycle 34 with result=0x0000002A.
- mulh, a=0x80000000, b=0x80000000 -> result=0x40000000. mulh, a=0xFFFFFFFF, b=1 -> result=0xFFFFFFFF.
- mulhsu, a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> result=0xFFFFFFFF. mulhu, same operands -> result=0xFFFFFFFE.
- Abort: kill asserted in cycle 10 of a mul -> no done; stall low from cycle 11; result keeps its prior value.
- rst asserted in cycle 5 of an operation -> next cycle state IDLE, stall=0, done=0, result=0.
- start with mulsel=000 or 111 -> stall never rises, no done. Start held during BUSY -> exactly one done. Start in the done cycle -> second done 34 cycles later with the correct value.
